// File: rtl/trace_disasm_arbiter_if.sv
// Stage-post, shared-disassembler and trace-record signals of trace_disasm_arbiter.
// The arbiter connects to the slave modport; stages and the trace sink connect to the master modport.
interface trace_disasm_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int SRC_W   = 3,
  parameter int DROP_W  = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_inst;
  logic [32*NUM_REQ-1:0] req_pc;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           dis_inst;
  logic [255:0]          dis_mips;
  logic                  out_valid;
  logic                  out_ready;
  logic [255:0]          out_mips;
  logic [31:0]           out_inst;
  logic [31:0]           out_pc;
  logic [SRC_W-1:0]      out_src;
  logic [DROP_W-1:0]     drop_count;

  modport master (
    output req_valid, req_inst, req_pc, dis_mips, out_ready,
    input  req_ready, dis_inst, out_valid, out_mips, out_inst, out_pc, out_src, drop_count
  );

  modport slave (
    input  req_valid, req_inst, req_pc, dis_mips, out_ready,
    output req_ready, dis_inst, out_valid, out_mips, out_inst, out_pc, out_src, drop_count
  );
endinterface

// File: rtl/trace_disasm_arbiter.sv
// Round-robin sharing of one combinational disassembler between pipeline stages for trace output.
// Each stage owns a one-entry post buffer; posts that find it full are dropped and counted.
module trace_disasm_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int SRC_W   = 3,
  parameter int DROP_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  trace_disasm_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, OUT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] full_q, full_d;
  logic [31:0]        buf_inst [NUM_REQ];
  logic [31:0]        buf_pc   [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [DROP_W-1:0]  drop_q;

  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic               take;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] accept_vec;
  logic [NUM_REQ-1:0] drop_vec;
  logic [SRC_W-1:0]   next_ptr;

  logic [31:0]        dis_inst_p0;
  logic [31:0]        lat_pc_p0;
  logic [SRC_W-1:0]   lat_src_p0;

  logic               vld_p1;
  logic [255:0]       out_mips_p1;
  logic [31:0]        out_inst_p1;
  logic [31:0]        out_pc_p1;
  logic [SRC_W-1:0]   out_src_p1;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQ; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  // First full buffer at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    logic [SRC_W:0] sum;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NUM_REQ)) sum = sum - (SRC_W+1)'(NUM_REQ);
      if (!grant_any && full_q[sum[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[SRC_W-1:0];
      end
    end
  end

  // A buffer granted this cycle frees its slot in time to accept a same-cycle post.
  always_comb begin
    take      = (state_q == IDLE) && grant_any;
    grant_vec = '0;
    if (take) grant_vec[grant_idx] = 1'b1;
    accept_vec = bus.req_valid & (~full_q | grant_vec);
    drop_vec   = bus.req_valid & full_q & ~grant_vec;
    full_d     = (full_q & ~grant_vec) | accept_vec;
    next_ptr   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = LOOKUP;
      LOOKUP:  state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_vec[i]) begin
        buf_inst[i] <= bus.req_inst[32*i +: 32];
        buf_pc[i]   <= bus.req_pc[32*i +: 32];
      end
    end
    if (take) begin
      lat_pc_p0  <= buf_pc[grant_idx];
      lat_src_p0 <= grant_idx;
    end
  end

  // p0: grant drives the disassembler; p1: registered trace record held until out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      full_q      <= '0;
      rr_ptr_q    <= '0;
      drop_q      <= '0;
      dis_inst_p0 <= '0;
      vld_p1      <= 1'b0;
      out_mips_p1 <= '0;
      out_inst_p1 <= '0;
      out_pc_p1   <= '0;
      out_src_p1  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      drop_q  <= sat_add(drop_q, popcount(drop_vec));
      if (take) begin
        dis_inst_p0 <= buf_inst[grant_idx];
        rr_ptr_q    <= next_ptr;
      end
      if (state_q == LOOKUP) begin
        vld_p1      <= 1'b1;
        out_mips_p1 <= bus.dis_mips;
        out_inst_p1 <= dis_inst_p0;
        out_pc_p1   <= lat_pc_p0;
        out_src_p1  <= lat_src_p0;
      end else if (state_q == OUT && bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ~full_q;
  assign bus.dis_inst   = dis_inst_p0;
  assign bus.out_valid  = vld_p1;
  assign bus.out_mips   = out_mips_p1;
  assign bus.out_inst   = out_inst_p1;
  assign bus.out_pc     = out_pc_p1;
  assign bus.out_src    = out_src_p1;
  assign bus.drop_count = drop_q;
endmodule
